// File: rtl/riscv_timer_access_ctrl_if.sv
// Bus bundle between the two requesters, the access controller and the machine timer.
//   Requester side : i_riscv_tctrl_req/we/addr0/addr1/wdata0/wdata1 in, o_riscv_tctrl_ack/rdata/busy out
//   Timer side     : o_riscv_tctrl_wren/rden/regsel/wdata out, i_riscv_tctrl_rdata in
// slave  = the access controller, master = the environment (requesters + timer).
interface riscv_timer_access_ctrl_if;
  logic [1:0]  i_riscv_tctrl_req;
  logic [1:0]  i_riscv_tctrl_we;
  logic [1:0]  i_riscv_tctrl_addr0;
  logic [1:0]  i_riscv_tctrl_addr1;
  logic [31:0] i_riscv_tctrl_wdata0;
  logic [31:0] i_riscv_tctrl_wdata1;
  logic [1:0]  o_riscv_tctrl_ack;
  logic [31:0] o_riscv_tctrl_rdata;
  logic        o_riscv_tctrl_busy;
  logic        o_riscv_tctrl_wren;
  logic        o_riscv_tctrl_rden;
  logic [1:0]  o_riscv_tctrl_regsel;
  logic [63:0] o_riscv_tctrl_wdata;
  logic [63:0] i_riscv_tctrl_rdata;

  modport slave (
    input  i_riscv_tctrl_req, i_riscv_tctrl_we, i_riscv_tctrl_addr0, i_riscv_tctrl_addr1,
           i_riscv_tctrl_wdata0, i_riscv_tctrl_wdata1, i_riscv_tctrl_rdata,
    output o_riscv_tctrl_ack, o_riscv_tctrl_rdata, o_riscv_tctrl_busy, o_riscv_tctrl_wren,
           o_riscv_tctrl_rden, o_riscv_tctrl_regsel, o_riscv_tctrl_wdata
  );

  modport master (
    output i_riscv_tctrl_req, i_riscv_tctrl_we, i_riscv_tctrl_addr0, i_riscv_tctrl_addr1,
           i_riscv_tctrl_wdata0, i_riscv_tctrl_wdata1, i_riscv_tctrl_rdata,
    input  o_riscv_tctrl_ack, o_riscv_tctrl_rdata, o_riscv_tctrl_busy, o_riscv_tctrl_wren,
           o_riscv_tctrl_rden, o_riscv_tctrl_regsel, o_riscv_tctrl_wdata
  );
endinterface

// File: rtl/riscv_timer_access_ctrl.sv
// Arbitrates 32-bit accesses from the hart LSU (port 0) and debug module (port 1) onto the
// 64-bit machine timer. Reads take IDLE->RD->RESP; writes do a read-merge-write IDLE->RD->WR->RESP.
// Ports:
//   i_riscv_tctrl_clk   clock shared with the timer
//   i_riscv_tctrl_rstn  asynchronous active-low reset
//   bus                 requester handshake and timer strobes (see riscv_timer_access_ctrl_if)
// Parameter FIXED_PRIO: 0 = round-robin on simultaneous requests, 1 = port 0 always wins.
module riscv_timer_access_ctrl #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                          i_riscv_tctrl_clk,
  input  logic                          i_riscv_tctrl_rstn,
  riscv_timer_access_ctrl_if.slave      bus
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMER_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e              state_q;
  logic                rr_last_q;   // port granted most recently
  logic                grant_q;
  logic                we_q;
  logic [1:0]          addr_q;
  logic [DATA_W-1:0]   wdata_in_q;
  logic [1:0]          ack_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                busy_q;
  logic                wren_q;
  logic                rden_q;
  logic [1:0]          regsel_q;
  logic [TIMER_W-1:0]  wdata_q;

  logic                grant_c;
  logic                sel_we_c;
  logic [1:0]          sel_addr_c;
  logic [DATA_W-1:0]   sel_wdata_c;

  // Winner selection for the IDLE cycle; on a tie round-robin favours the port not granted last.
  always_comb begin
    grant_c = 1'b0;
    unique case (bus.i_riscv_tctrl_req)
      2'b01:   grant_c = 1'b0;
      2'b10:   grant_c = 1'b1;
      2'b11:   grant_c = FIXED_PRIO ? 1'b0 : ~rr_last_q;
      default: grant_c = 1'b0;
    endcase
    sel_we_c    = grant_c ? bus.i_riscv_tctrl_we[1]   : bus.i_riscv_tctrl_we[0];
    sel_addr_c  = grant_c ? bus.i_riscv_tctrl_addr1  : bus.i_riscv_tctrl_addr0;
    sel_wdata_c = grant_c ? bus.i_riscv_tctrl_wdata1 : bus.i_riscv_tctrl_wdata0;
  end

  // Sequencer: all outputs are registered, so strobes for a state are set on the edge entering it.
  always_ff @(posedge i_riscv_tctrl_clk or negedge i_riscv_tctrl_rstn) begin
    if (!i_riscv_tctrl_rstn) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b1;
      grant_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 2'b00;
      wdata_in_q <= '0;
      ack_q      <= 2'b00;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      wren_q     <= 1'b0;
      rden_q     <= 1'b0;
      regsel_q   <= 2'b00;
      wdata_q    <= '0;
    end else begin
      ack_q    <= 2'b00;
      rdata_q  <= '0;
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;
      regsel_q <= 2'b00;
      wdata_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (|bus.i_riscv_tctrl_req) begin
            grant_q    <= grant_c;
            rr_last_q  <= grant_c;
            we_q       <= sel_we_c;
            addr_q     <= sel_addr_c;
            wdata_in_q <= sel_wdata_c;
            busy_q     <= 1'b1;
            rden_q     <= 1'b1;
            regsel_q   <= sel_addr_c[1] ? 2'b10 : 2'b01;
            state_q    <= RD;
          end
        end
        RD: begin
          // Timer read data is valid this cycle; merge or return it on this edge.
          if (we_q) begin
            wren_q   <= 1'b1;
            regsel_q <= addr_q[1] ? 2'b10 : 2'b01;
            wdata_q  <= addr_q[0]
                        ? {wdata_in_q, bus.i_riscv_tctrl_rdata[DATA_W-1:0]}
                        : {bus.i_riscv_tctrl_rdata[TIMER_W-1:DATA_W], wdata_in_q};
            state_q  <= WR;
          end else begin
            ack_q   <= grant_q ? 2'b10 : 2'b01;
            rdata_q <= addr_q[0] ? bus.i_riscv_tctrl_rdata[TIMER_W-1:DATA_W]
                                 : bus.i_riscv_tctrl_rdata[DATA_W-1:0];
            state_q <= RESP;
          end
        end
        WR: begin
          ack_q   <= grant_q ? 2'b10 : 2'b01;
          state_q <= RESP;
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_riscv_tctrl_ack    = ack_q;
  assign bus.o_riscv_tctrl_rdata  = rdata_q;
  assign bus.o_riscv_tctrl_busy   = busy_q;
  assign bus.o_riscv_tctrl_wren   = wren_q;
  assign bus.o_riscv_tctrl_rden   = rden_q;
  assign bus.o_riscv_tctrl_regsel = regsel_q;
  assign bus.o_riscv_tctrl_wdata  = wdata_q;

endmodule

// File: tb/tb_riscv_timer_access_ctrl.sv
// Directed bench for riscv_timer_access_ctrl: a round-robin instance (dut0) and a fixed-priority
// instance (dut1) share the same requester stimulus; each sees its own timer model.
module tb_riscv_timer_access_ctrl;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;

  riscv_timer_access_ctrl_if tif0 ();
  riscv_timer_access_ctrl_if tif1 ();

  riscv_timer_access_ctrl #(.FIXED_PRIO(1'b0)) dut0 (
    .i_riscv_tctrl_clk  (clk),
    .i_riscv_tctrl_rstn (rstn),
    .bus                (tif0)
  );

  riscv_timer_access_ctrl #(.FIXED_PRIO(1'b1)) dut1 (
    .i_riscv_tctrl_clk  (clk),
    .i_riscv_tctrl_rstn (rstn),
    .bus                (tif1)
  );

  // Shared requester inputs for the fixed-priority instance.
  assign tif1.i_riscv_tctrl_req    = tif0.i_riscv_tctrl_req;
  assign tif1.i_riscv_tctrl_we     = tif0.i_riscv_tctrl_we;
  assign tif1.i_riscv_tctrl_addr0  = tif0.i_riscv_tctrl_addr0;
  assign tif1.i_riscv_tctrl_addr1  = tif0.i_riscv_tctrl_addr1;
  assign tif1.i_riscv_tctrl_wdata0 = tif0.i_riscv_tctrl_wdata0;
  assign tif1.i_riscv_tctrl_wdata1 = tif0.i_riscv_tctrl_wdata1;

  // Timer model: combinational read data from rden/regsel.
  assign tif0.i_riscv_tctrl_rdata = !tif0.o_riscv_tctrl_rden ? 64'd0 :
                                    (tif0.o_riscv_tctrl_regsel == 2'b01) ? mtime :
                                    (tif0.o_riscv_tctrl_regsel == 2'b10) ? mtimecmp : 64'd0;
  assign tif1.i_riscv_tctrl_rdata = !tif1.o_riscv_tctrl_rden ? 64'd0 :
                                    (tif1.o_riscv_tctrl_regsel == 2'b01) ? mtime :
                                    (tif1.o_riscv_tctrl_regsel == 2'b10) ? mtimecmp : 64'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  exp_regsel;
    logic [31:0] exp_rdata;
    logic [63:0] exp_wdata;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tif0.i_riscv_tctrl_req    = 2'b00;
    tif0.i_riscv_tctrl_we     = 2'b00;
    tif0.i_riscv_tctrl_addr0  = 2'b00;
    tif0.i_riscv_tctrl_addr1  = 2'b00;
    tif0.i_riscv_tctrl_wdata0 = 32'd0;
    tif0.i_riscv_tctrl_wdata1 = 32'd0;
  endtask

  // One isolated transaction, checked cycle by cycle against the vector.
  task automatic run_txn(input vec_t v, input int idx);
    logic [1:0] exp_ack;
    exp_ack = v.port ? 2'b10 : 2'b01;
    tif0.i_riscv_tctrl_req    = exp_ack;
    tif0.i_riscv_tctrl_we     = {v.we, v.we};
    tif0.i_riscv_tctrl_addr0  = v.addr;
    tif0.i_riscv_tctrl_addr1  = v.addr;
    tif0.i_riscv_tctrl_wdata0 = v.wdata;
    tif0.i_riscv_tctrl_wdata1 = v.wdata;
    tick();  // RD
    check($sformatf("v%0d rd rden", idx), 64'(tif0.o_riscv_tctrl_rden), 64'd1);
    check($sformatf("v%0d rd regsel", idx), 64'(tif0.o_riscv_tctrl_regsel), 64'(v.exp_regsel));
    check($sformatf("v%0d rd ack", idx), 64'(tif0.o_riscv_tctrl_ack), 64'd0);
    check($sformatf("v%0d rd rdata", idx), 64'(tif0.o_riscv_tctrl_rdata), 64'd0);
    if (v.we) begin
      tick();  // WR
      check($sformatf("v%0d wr wren", idx), 64'(tif0.o_riscv_tctrl_wren), 64'd1);
      check($sformatf("v%0d wr rden", idx), 64'(tif0.o_riscv_tctrl_rden), 64'd0);
      check($sformatf("v%0d wr regsel", idx), 64'(tif0.o_riscv_tctrl_regsel), 64'(v.exp_regsel));
      check($sformatf("v%0d wr wdata", idx), tif0.o_riscv_tctrl_wdata, v.exp_wdata);
      check($sformatf("v%0d wr ack", idx), 64'(tif0.o_riscv_tctrl_ack), 64'd0);
    end
    tick();  // RESP
    check($sformatf("v%0d ack", idx), 64'(tif0.o_riscv_tctrl_ack), 64'(exp_ack));
    check($sformatf("v%0d rdata", idx), 64'(tif0.o_riscv_tctrl_rdata), 64'(v.exp_rdata));
    check($sformatf("v%0d resp strobes", idx),
          64'({tif0.o_riscv_tctrl_wren, tif0.o_riscv_tctrl_rden}), 64'd0);
    check($sformatf("v%0d resp busy", idx), 64'(tif0.o_riscv_tctrl_busy), 64'd1);
    idle_inputs();
    tick();  // IDLE
    check($sformatf("v%0d idle busy", idx), 64'(tif0.o_riscv_tctrl_busy), 64'd0);
    check($sformatf("v%0d idle ack", idx), 64'(tif0.o_riscv_tctrl_ack), 64'd0);
  endtask

  initial begin
    logic [1:0] acks0 [$];
    logic [1:0] acks1 [$];
    logic [1:0] exp_rr [4];

    vecs[0] = '{1'b0, 1'b0, 2'b01, 32'h0,         2'b01, 32'h0000_0001, 64'h0};
    vecs[1] = '{1'b1, 1'b1, 2'b10, 32'hDEAD_BEEF, 2'b10, 32'h0,         64'h1111_2222_DEAD_BEEF};
    vecs[2] = '{1'b0, 1'b0, 2'b00, 32'h0,         2'b01, 32'hFFFF_FFF0, 64'h0};
    vecs[3] = '{1'b1, 1'b0, 2'b11, 32'h0,         2'b10, 32'h1111_2222, 64'h0};
    vecs[4] = '{1'b0, 1'b1, 2'b11, 32'hCAFE_F00D, 2'b10, 32'h0,         64'hCAFE_F00D_3333_4444};
    vecs[5] = '{1'b1, 1'b1, 2'b00, 32'h1234_5678, 2'b01, 32'h0,         64'h0000_0001_1234_5678};
    vecs[6] = '{1'b0, 1'b0, 2'b10, 32'h0,         2'b10, 32'h3333_4444, 64'h0};
    vecs[7] = '{1'b1, 1'b1, 2'b01, 32'hA5A5_A5A5, 2'b01, 32'h0,         64'hA5A5_A5A5_FFFF_FFF0};

    n_checks = 0;
    n_fail   = 0;
    mtime    = 64'h0000_0001_FFFF_FFF0;
    mtimecmp = 64'h1111_2222_3333_4444;
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    check("reset ack/busy/strobes",
          64'({tif0.o_riscv_tctrl_ack, tif0.o_riscv_tctrl_busy,
               tif0.o_riscv_tctrl_wren, tif0.o_riscv_tctrl_rden, tif0.o_riscv_tctrl_regsel}), 64'd0);
    check("reset rdata", 64'(tif0.o_riscv_tctrl_rdata), 64'd0);
    check("reset wdata", tif0.o_riscv_tctrl_wdata, 64'd0);
    rstn = 1'b1;
    tick();

    // Single-port transactions.
    for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

    // Both ports reading continuously: round-robin alternates, fixed priority always port 0.
    exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10};
    tif0.i_riscv_tctrl_req   = 2'b11;
    tif0.i_riscv_tctrl_we    = 2'b00;
    tif0.i_riscv_tctrl_addr0 = 2'b01;
    tif0.i_riscv_tctrl_addr1 = 2'b11;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (tif0.o_riscv_tctrl_ack != 2'b00) acks0.push_back(tif0.o_riscv_tctrl_ack);
      if (tif1.o_riscv_tctrl_ack != 2'b00) acks1.push_back(tif1.o_riscv_tctrl_ack);
    end
    idle_inputs();
    check("rr ack count", 64'(acks0.size()), 64'd4);
    check("fixed ack count", 64'(acks1.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < acks0.size()) check($sformatf("rr grant %0d", k), 64'(acks0[k]), 64'(exp_rr[k]));
      if (k < acks1.size()) check($sformatf("fixed grant %0d", k), 64'(acks1[k]), 64'd1);
    end
    tick();
    tick();
    tick();

    // Reset asserted in the WR cycle of a port 0 write.
    tif0.i_riscv_tctrl_req    = 2'b01;
    tif0.i_riscv_tctrl_we     = 2'b01;
    tif0.i_riscv_tctrl_addr0  = 2'b11;
    tif0.i_riscv_tctrl_wdata0 = 32'h5555_AAAA;
    tick();  // RD
    tick();  // WR
    check("rst-mid wren before", 64'(tif0.o_riscv_tctrl_wren), 64'd1);
    rstn = 1'b0;
    #1;
    check("rst-mid wren", 64'(tif0.o_riscv_tctrl_wren), 64'd0);
    check("rst-mid busy", 64'(tif0.o_riscv_tctrl_busy), 64'd0);
    check("rst-mid regsel", 64'(tif0.o_riscv_tctrl_regsel), 64'd0);
    idle_inputs();
    tick();
    check("rst-mid no ack", 64'(tif0.o_riscv_tctrl_ack), 64'd0);
    rstn = 1'b1;
    tick();
    check("post-rst no ack", 64'(tif0.o_riscv_tctrl_ack), 64'd0);
    tif0.i_riscv_tctrl_req   = 2'b11;
    tif0.i_riscv_tctrl_addr0 = 2'b00;
    tif0.i_riscv_tctrl_addr1 = 2'b00;
    tick();
    tick();
    check("post-rst tie winner rr", 64'(tif0.o_riscv_tctrl_ack), 64'd1);
    check("post-rst tie winner fixed", 64'(tif1.o_riscv_tctrl_ack), 64'd1);
    check("post-rst rdata", 64'(tif0.o_riscv_tctrl_rdata), 64'hFFFF_FFF0);
    idle_inputs();
    tick();
    tick();

    // Port 0 drops req during RD of a read: still acked, no new grant afterwards.
    tif0.i_riscv_tctrl_req   = 2'b01;
    tif0.i_riscv_tctrl_addr0 = 2'b10;
    tick();  // RD
    tif0.i_riscv_tctrl_req = 2'b00;
    tick();  // RESP
    check("drop ack", 64'(tif0.o_riscv_tctrl_ack), 64'd1);
    check("drop rdata", 64'(tif0.o_riscv_tctrl_rdata), 64'h3333_4444);
    tick();  // IDLE
    check("drop idle busy", 64'(tif0.o_riscv_tctrl_busy), 64'd0);
    tick();
    check("drop no regrant rden", 64'(tif0.o_riscv_tctrl_rden), 64'd0);
    check("drop no regrant busy", 64'(tif0.o_riscv_tctrl_busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
